// File: rtl/uart_frame_pkg.sv
// rtl/uart_frame_pkg.sv - shared types and constants for the UART frame sequencer
package uart_frame_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CMD     = 3'd1,
        LEN     = 3'd2,
        PAYLOAD = 3'd3,
        CHK     = 3'd4,
        HOLD    = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        ERR_NONE     = 3'd0,
        ERR_PARITY   = 3'd1,
        ERR_BADLEN   = 3'd2,
        ERR_CHECKSUM = 3'd3,
        ERR_TIMEOUT  = 3'd4,
        ERR_OVERRUN  = 3'd5
    } err_code_t;

    localparam logic [7:0] CRC8_POLY         = 8'h07;
    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    // One byte of CRC-8, MSB-first, no reflection.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/frame_chk_accum.sv
// rtl/frame_chk_accum.sv - running frame checksum; CRC-8 when UART_FRAME_CRC8_EN is defined, XOR otherwise
module frame_chk_accum
    import uart_frame_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       clear_i,
    input  logic       en_i,
    input  logic [7:0] data_i,
    output logic [7:0] sum_o
);

    logic [7:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clear_i) begin
            sum_d = 8'h00;
        end else if (en_i) begin
`ifdef UART_FRAME_CRC8_EN
            sum_d = crc8_step(sum_q, data_i);
`else
            sum_d = sum_q ^ data_i;
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sum_q <= 8'h00;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// rtl/uart_rx_frame_ctrl.sv - parses SYNC/CMD/LEN/PAYLOAD/CHK frames from the UART byte stream (UART_FRAME_CRC8_EN selects CRC-8 checksum)
module uart_rx_frame_ctrl
    import uart_frame_pkg::*;
#(
    parameter int         MAX_PAYLOAD    = 8,
    parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter int         TIMEOUT_CYCLES = 100_000
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic [7:0]                         i_rx_byte,
    input  logic                               i_rx_byte_valid,
    input  logic                               i_rx_err,
    output logic [7:0]                         o_cmd,
    output logic [$clog2(MAX_PAYLOAD+1)-1:0]   o_len,
    output logic [8*MAX_PAYLOAD-1:0]           o_payload,
    output logic                               o_frame_valid,
    input  logic                               i_frame_ready,
    output logic                               o_busy,
    output logic                               o_err_valid,
    output logic [2:0]                         o_err_code
);

    localparam int LW = $clog2(MAX_PAYLOAD + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]    MAX_B    = 8'(MAX_PAYLOAD);
    // Error fires on the idle cycle that would bring the count to TIMEOUT_CYCLES-1.
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 2);

    state_t                   state_q, state_d;
    logic [7:0]               cmd_q, cmd_d;
    logic [LW-1:0]            len_q, len_d;
    logic [LW-1:0]            idx_q, idx_d;
    logic [LW-1:0]            idx_nxt;
    logic [8*MAX_PAYLOAD-1:0] payload_q, payload_d;
    logic [TW-1:0]            tmo_q, tmo_d;
    logic                     err_valid_q, err_valid_d;
    err_code_t                err_code_q, err_code_d;
    logic                     acc_clr, acc_en, byte_ok;
    logic [7:0]               acc_sum;

    frame_chk_accum u_accum (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .clear_i (acc_clr),
        .en_i    (acc_en),
        .data_i  (i_rx_byte),
        .sum_o   (acc_sum)
    );

    assign byte_ok = i_rx_byte_valid && !i_rx_err;
    assign idx_nxt = idx_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        len_d       = len_q;
        idx_d       = idx_q;
        payload_d   = payload_q;
        tmo_d       = tmo_q;
        err_valid_d = 1'b0;
        err_code_d  = err_code_q;
        acc_clr     = 1'b0;
        acc_en      = 1'b0;

        case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (i_rx_err) begin
                    err_valid_d = 1'b1;
                    err_code_d  = ERR_PARITY;
                end else if (byte_ok && i_rx_byte == SYNC_BYTE) begin
                    state_d = CMD;
                    acc_clr = 1'b1;
                end
            end

            HOLD: begin
                tmo_d = '0;
                if (i_rx_err) begin
                    err_valid_d = 1'b1;
                    err_code_d  = ERR_PARITY;
                end
                // A byte landing with the handshake is treated as the first IDLE byte.
                if (i_frame_ready) begin
                    state_d = IDLE;
                    if (byte_ok && i_rx_byte == SYNC_BYTE) begin
                        state_d = CMD;
                        acc_clr = 1'b1;
                    end
                end else if (byte_ok) begin
                    err_valid_d = 1'b1;
                    err_code_d  = ERR_OVERRUN;
                end
            end

            default: begin
                if (i_rx_err) begin
                    err_valid_d = 1'b1;
                    err_code_d  = ERR_PARITY;
                    state_d     = IDLE;
                    tmo_d       = '0;
                end else if (i_rx_byte_valid) begin
                    tmo_d = '0;
                    case (state_q)
                        CMD: begin
                            cmd_d     = i_rx_byte;
                            payload_d = '0;
                            acc_en    = 1'b1;
                            state_d   = LEN;
                        end
                        LEN: begin
                            if (i_rx_byte > MAX_B) begin
                                err_valid_d = 1'b1;
                                err_code_d  = ERR_BADLEN;
                                state_d     = IDLE;
                            end else begin
                                len_d   = i_rx_byte[LW-1:0];
                                idx_d   = '0;
                                acc_en  = 1'b1;
                                state_d = (i_rx_byte == 8'h00) ? CHK : PAYLOAD;
                            end
                        end
                        PAYLOAD: begin
                            for (int i = 0; i < MAX_PAYLOAD; i++) begin
                                if (idx_q == LW'(i)) begin
                                    payload_d[8*i +: 8] = i_rx_byte;
                                end
                            end
                            acc_en = 1'b1;
                            idx_d  = idx_nxt;
                            if (idx_nxt == len_q) begin
                                state_d = CHK;
                            end
                        end
                        default: begin
                            if (i_rx_byte == acc_sum) begin
                                state_d = HOLD;
                            end else begin
                                err_valid_d = 1'b1;
                                err_code_d  = ERR_CHECKSUM;
                                state_d     = IDLE;
                            end
                        end
                    endcase
                end else if (tmo_q == TMO_LAST) begin
                    err_valid_d = 1'b1;
                    err_code_d  = ERR_TIMEOUT;
                    state_d     = IDLE;
                    tmo_d       = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            cmd_q       <= 8'h00;
            len_q       <= '0;
            idx_q       <= '0;
            payload_q   <= '0;
            tmo_q       <= '0;
            err_valid_q <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            payload_q   <= payload_d;
            tmo_q       <= tmo_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
        end
    end

    assign o_cmd         = cmd_q;
    assign o_len         = len_q;
    assign o_payload     = payload_q;
    assign o_frame_valid = (state_q == HOLD);
    assign o_busy        = (state_q != IDLE);
    assign o_err_valid   = err_valid_q;
    assign o_err_code    = err_code_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb/tb_uart_rx_frame_ctrl.sv - self-checking bench for uart_rx_frame_ctrl against a byte-buffer frame model
module tb_uart_rx_frame_ctrl;

    localparam int MAXP = 8;
    localparam int TMO  = 50;

    typedef logic [7:0] bq_t[$];

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [7:0]  i_rx_byte = 8'h00;
    logic        i_rx_byte_valid = 1'b0;
    logic        i_rx_err = 1'b0;
    logic        i_frame_ready = 1'b0;
    logic [7:0]  o_cmd;
    logic [3:0]  o_len;
    logic [63:0] o_payload;
    logic        o_frame_valid;
    logic        o_busy;
    logic        o_err_valid;
    logic [2:0]  o_err_code;

    int n_checks = 0;
    int n_errors = 0;
    logic cmp_en = 1'b0;

    // Frame model: bytes collected since SYNC, plus a held-frame flag.
    bq_t         m_buf;
    logic        m_in_frame = 1'b0;
    logic        m_hold = 1'b0;
    int          m_idle = 0;
    logic [7:0]  m_cmd = 8'h00;
    logic [3:0]  m_len = 4'h0;
    logic [63:0] m_payload = 64'h0;
    logic        m_err_v = 1'b0;
    logic [2:0]  m_err_code = 3'd0;

    uart_rx_frame_ctrl #(
        .MAX_PAYLOAD    (MAXP),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_rx_byte       (i_rx_byte),
        .i_rx_byte_valid (i_rx_byte_valid),
        .i_rx_err        (i_rx_err),
        .o_cmd           (o_cmd),
        .o_len           (o_len),
        .o_payload       (o_payload),
        .o_frame_valid   (o_frame_valid),
        .i_frame_ready   (i_frame_ready),
        .o_busy          (o_busy),
        .o_err_valid     (o_err_valid),
        .o_err_code      (o_err_code)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] xor_sum(input bq_t q, input int cnt);
        logic [7:0] s = 8'h00;
        for (int i = 0; i < cnt; i++) s ^= q[i];
        return s;
    endfunction

    // Bit-serial polynomial division of the message, MSB-first.
    function automatic logic [7:0] crc8_sum(input bq_t q, input int cnt);
        logic [7:0] r = 8'h00;
        logic       fb;
        for (int i = 0; i < cnt; i++) begin
            for (int b = 7; b >= 0; b--) begin
                fb = r[7] ^ q[i][b];
                r  = {r[6:0], 1'b0};
                if (fb) r ^= 8'h07;
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] model_csum(input bq_t q, input int cnt);
`ifdef UART_FRAME_CRC8_EN
        return crc8_sum(q, cnt);
`else
        return xor_sum(q, cnt);
`endif
    endfunction

    task automatic m_error(input logic [2:0] code);
        m_err_v    = 1'b1;
        m_err_code = code;
    endtask

    task automatic m_start();
        m_in_frame = 1'b1;
        m_buf.delete();
        m_idle = 0;
    endtask

    task automatic model_step();
        int n;
        logic [7:0] b;
        b = i_rx_byte;
        m_err_v = 1'b0;
        if (!i_rst_n) begin
            m_in_frame = 1'b0; m_hold = 1'b0; m_idle = 0; m_buf.delete();
            m_cmd = 8'h00; m_len = 4'h0; m_payload = 64'h0; m_err_code = 3'd0;
            return;
        end
        if (m_hold) begin
            if (i_rx_err) m_error(3'd1);
            if (i_frame_ready) begin
                m_hold = 1'b0;
                if (i_rx_byte_valid && !i_rx_err && b == 8'hA5) m_start();
            end else if (i_rx_byte_valid && !i_rx_err) begin
                m_error(3'd5);
            end
        end else if (m_in_frame) begin
            if (i_rx_err) begin
                m_error(3'd1);
                m_in_frame = 1'b0;
            end else if (i_rx_byte_valid) begin
                m_buf.push_back(b);
                m_idle = 0;
                n = m_buf.size();
                if (n == 1) begin
                    m_cmd = b;
                    m_payload = 64'h0;
                end else if (n == 2) begin
                    if (int'(b) > MAXP) begin
                        m_error(3'd2);
                        m_in_frame = 1'b0;
                    end else begin
                        m_len = b[3:0];
                    end
                end else if (n == 3 + int'(m_buf[1])) begin
                    m_in_frame = 1'b0;
                    if (b == model_csum(m_buf, n - 1)) m_hold = 1'b1;
                    else m_error(3'd3);
                end else begin
                    m_payload[8*(n-3) +: 8] = b;
                end
            end else begin
                m_idle++;
                if (m_idle == TMO - 1) begin
                    m_error(3'd4);
                    m_in_frame = 1'b0;
                end
            end
        end else begin
            if (i_rx_err) m_error(3'd1);
            else if (i_rx_byte_valid && b == 8'hA5) m_start();
        end
    endtask

    initial begin
        forever begin
            @(posedge i_clk);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge i_clk);
            if (cmp_en) begin
                check("cmp_cmd",         {56'h0, o_cmd},         {56'h0, m_cmd});
                check("cmp_len",         {60'h0, o_len},         {60'h0, m_len});
                check("cmp_payload",     o_payload,              m_payload);
                check("cmp_frame_valid", {63'h0, o_frame_valid}, {63'h0, m_hold});
                check("cmp_busy",        {63'h0, o_busy},        {63'h0, (m_hold | m_in_frame)});
                check("cmp_err_valid",   {63'h0, o_err_valid},   {63'h0, m_err_v});
                check("cmp_err_code",    {61'h0, o_err_code},    {61'h0, m_err_code});
            end
        end
    end

    task automatic cyc(input logic v, input logic [7:0] b, input logic e, input logic r);
        i_rx_byte_valid = v;
        i_rx_byte       = b;
        i_rx_err        = e;
        i_frame_ready   = r;
        @(posedge i_clk);
        #1;
        i_rx_byte_valid = 1'b0;
        i_rx_err        = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] cmd, input bq_t pl, input logic [7:0] chk_flip, input logic r);
        bq_t body;
        body.push_back(cmd);
        body.push_back(8'(pl.size()));
        foreach (pl[i]) body.push_back(pl[i]);
        cyc(1'b1, 8'hA5, 1'b0, r);
        foreach (body[i]) cyc(1'b1, body[i], 1'b0, r);
        cyc(1'b1, model_csum(body, body.size()) ^ chk_flip, 1'b0, r);
    endtask

    initial begin
        bq_t q;
        bq_t none;

        // Pin the model's checksum helpers.
        q = '{8'h10, 8'h02, 8'h11, 8'h22};
        check("pin_xor", {56'h0, xor_sum(q, 4)}, 64'h21);
        q = '{8'h01, 8'h00};
        check("pin_crc8", {56'h0, crc8_sum(q, 2)}, 64'h15);

        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cmp_en = 1'b1;
        cyc(1'b1, 8'hA5, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        check("rst_busy", {63'h0, o_busy}, 64'h0);
        check("rst_err_code", {61'h0, o_err_code}, 64'h0);
        check("rst_frame_valid", {63'h0, o_frame_valid}, 64'h0);
        i_rst_n = 1'b1;
        cyc(1'b0, 8'h00, 1'b0, 1'b1);

        // Good frame, consumer ready.
        q = '{8'h11, 8'h22};
        send_frame(8'h10, q, 8'h00, 1'b1);
        check("t1_valid", {63'h0, o_frame_valid}, 64'h1);
        check("t1_cmd", {56'h0, o_cmd}, 64'h10);
        check("t1_len", {60'h0, o_len}, 64'h2);
        check("t1_payload", {48'h0, o_payload[15:0]}, 64'h2211);
        check("t1_model_len", {60'h0, m_len}, 64'h2);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        check("t1_valid_drop", {63'h0, o_frame_valid}, 64'h0);

        // Bad checksum.
        send_frame(8'h10, q, 8'h01, 1'b1);
        check("t2_err_valid", {63'h0, o_err_valid}, 64'h1);
        check("t2_err_code", {61'h0, o_err_code}, 64'h3);
        check("t2_busy", {63'h0, o_busy}, 64'h0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        check("t2_err_pulse", {63'h0, o_err_valid}, 64'h0);
        check("t2_code_hold", {61'h0, o_err_code}, 64'h3);

        // Length above MAX, then zero-length frame.
        cyc(1'b1, 8'hA5, 1'b0, 1'b1);
        cyc(1'b1, 8'h07, 1'b0, 1'b1);
        cyc(1'b1, 8'h09, 1'b0, 1'b1);
        check("t3_badlen", {61'h0, o_err_code}, 64'h2);
        check("t3_busy", {63'h0, o_busy}, 64'h0);
        send_frame(8'h07, none, 8'h00, 1'b1);
        check("t3_valid", {63'h0, o_frame_valid}, 64'h1);
        check("t3_len0", {60'h0, o_len}, 64'h0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);

        // Maximum payload length.
        q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        send_frame(8'h3C, q, 8'h00, 1'b1);
        check("t3_max_payload", o_payload, 64'h0807060504030201);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);

        // Inter-byte timeout.
        cyc(1'b1, 8'hA5, 1'b0, 1'b1);
        cyc(1'b1, 8'h30, 1'b0, 1'b1);
        for (int i = 0; i < TMO - 2; i++) cyc(1'b0, 8'h00, 1'b0, 1'b1);
        check("t4_no_err_yet", {63'h0, o_err_valid}, 64'h0);
        check("t4_busy_yet", {63'h0, o_busy}, 64'h1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        check("t4_timeout", {61'h0, o_err_code}, 64'h4);
        check("t4_timeout_v", {63'h0, o_err_valid}, 64'h1);
        check("t4_idle", {63'h0, o_busy}, 64'h0);

        // Overrun while held, then simultaneous ready + SYNC.
        q = '{8'h5A};
        send_frame(8'h01, q, 8'h00, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b1, 8'h55, 1'b0, 1'b0);
        check("t5_overrun", {61'h0, o_err_code}, 64'h5);
        check("t5_still_valid", {63'h0, o_frame_valid}, 64'h1);
        check("t5_payload", {56'h0, o_payload[7:0]}, 64'h5A);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("t5_parity_hold", {61'h0, o_err_code}, 64'h1);
        check("t5_retained", {63'h0, o_frame_valid}, 64'h1);
        cyc(1'b1, 8'hA5, 1'b0, 1'b1);
        check("t5_xfer_done", {63'h0, o_frame_valid}, 64'h0);
        check("t5_next_busy", {63'h0, o_busy}, 64'h1);
        q = '{8'h02, 8'h00};
        cyc(1'b1, 8'h02, 1'b0, 1'b1);
        cyc(1'b1, 8'h00, 1'b0, 1'b1);
        cyc(1'b1, model_csum(q, 2), 1'b0, 1'b1);
        check("t5_next_valid", {63'h0, o_frame_valid}, 64'h1);
        check("t5_next_cmd", {56'h0, o_cmd}, 64'h02);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);

        // Parity error mid-payload, with a coincident byte strobe.
        cyc(1'b1, 8'hA5, 1'b0, 1'b1);
        cyc(1'b1, 8'h03, 1'b0, 1'b1);
        cyc(1'b1, 8'h03, 1'b0, 1'b1);
        cyc(1'b1, 8'hAA, 1'b0, 1'b1);
        cyc(1'b1, 8'hBB, 1'b1, 1'b1);
        check("t6_parity", {61'h0, o_err_code}, 64'h1);
        check("t6_idle", {63'h0, o_busy}, 64'h0);
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        check("t6_idle_parity", {63'h0, o_err_valid}, 64'h1);
        check("t6_idle_stay", {63'h0, o_busy}, 64'h0);

        // Short frame (CRC-8 of 01,00 is 15 in the CRC build).
        send_frame(8'h01, none, 8'h00, 1'b1);
        check("t7_accept", {63'h0, o_frame_valid}, 64'h1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);

        // Reset mid-frame discards it.
        cyc(1'b1, 8'hA5, 1'b0, 1'b1);
        cyc(1'b1, 8'h44, 1'b0, 1'b1);
        i_rst_n = 1'b0;
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        i_rst_n = 1'b1;
        check("t8_rst_busy", {63'h0, o_busy}, 64'h0);
        check("t8_rst_cmd", {56'h0, o_cmd}, 64'h0);
        q = '{8'hC3, 8'h3C, 8'hFF};
        send_frame(8'h66, q, 8'h00, 1'b1);
        check("t8_after_rst", {63'h0, o_frame_valid}, 64'h1);
        check("t8_payload", {40'h0, o_payload[23:0]}, 64'hFF3CC3);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
